// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter between
// the instruction-fetch (I) and load/store (D) requesters.
package riscv_mem_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    localparam logic [DEF_DW/8-1:0] BE_ALL = '1;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/riscv_arb_prio.sv
// Grant selection between fetch and data requesters: data has priority,
// a saturating streak counter forces a fetch grant after MAX_D_STREAK data wins.
module riscv_arb_prio #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_idle,
    input  logic i_i_req,
    input  logic i_d_req,
    output logic o_grant_i,
    output logic o_grant_d
);

    logic [3:0] r_streak;
    logic       w_limit;

    always_comb begin
        w_limit   = i_i_req && (r_streak == 4'(MAX_D_STREAK));
        o_grant_d = i_idle && i_d_req && !w_limit;
        o_grant_i = i_idle && i_i_req && !o_grant_d;
    end

    // Counts only D wins that made a waiting fetch wait longer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (i_idle) begin
            if (o_grant_i || !i_i_req) begin
                r_streak <= '0;
            end else if (o_grant_d && (r_streak != 4'(MAX_D_STREAK))) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional watchdog: define RISCV_MEM_ARB_TIMEOUT_EN to enable timeout acks with err.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned AW             = DEF_AW,
    parameter int unsigned DW             = DEF_DW,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_ack,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            err
);

    arb_state_t r_state, w_state_nxt;

    logic            w_grant_i, w_grant_d, w_winner;
    logic            w_done, w_tmo;
    logic            r_mem_req, r_mem_we, r_i_ack, r_d_ack;
    logic [DW/8-1:0] r_mem_be;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata, r_i_rdata, r_d_rdata;

    riscv_arb_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .i_idle   (r_state == ST_IDLE),
        .i_i_req  (i_req),
        .i_d_req  (d_req),
        .o_grant_i(w_grant_i),
        .o_grant_d(w_grant_d)
    );

    assign w_winner = w_grant_d ? REQ_D : REQ_I;

`ifdef RISCV_MEM_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wdog;
    logic            r_err;

    // Zero throughout IDLE, so every WAIT entry starts from zero.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_IDLE)) r_wdog <= '0;
        else                             r_wdog <= r_wdog + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_tmo;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_d)      w_state_nxt = ST_WAIT_D;
                else if (w_grant_i) w_state_nxt = ST_WAIT_I;
            end
            ST_WAIT_I, ST_WAIT_D: begin
                if (mem_rvalid) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef RISCV_MEM_ARB_TIMEOUT_EN
                else if (r_wdog == WD_W'(TIMEOUT_CYCLES)) begin
                    w_done      = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_req <= w_grant_i || w_grant_d;
            r_i_ack   <= w_done && (r_state == ST_WAIT_I);
            r_d_ack   <= w_done && (r_state == ST_WAIT_D);
            // Read data is zeroed outside ack cycles, for stores and on timeout.
            r_i_rdata <= (w_done && !w_tmo && (r_state == ST_WAIT_I)) ? mem_rdata : '0;
            r_d_rdata <= (w_done && !w_tmo && !r_mem_we && (r_state == ST_WAIT_D)) ?
                         mem_rdata : '0;
            if (w_grant_i || w_grant_d) begin
                if (w_winner == REQ_D) begin
                    r_mem_we    <= d_we;
                    r_mem_be    <= d_be;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_be    <= '1;
                    r_mem_addr  <= i_addr;
                    r_mem_wdata <= '0;
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus random traffic
// scored against a transaction-level timing model and a behavioural memory.
module tb_riscv_mem_arbiter;
    import riscv_mem_pkg::*;

    localparam int unsigned MAXS = 4;
    localparam int unsigned TMO  = 8;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack, d_req, d_we, d_ack, mem_req, mem_we, mem_rvalid, err;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_be, mem_be;

    riscv_mem_arbiter #(
        .AW(32), .DW(32), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: pending requests, memory image, one scheduled transaction.
    logic [31:0] i_q[$];
    dreq_t       d_q[$];
    logic [31:0] mem [0:255];
    int cyc = 0;
    int free_at = 0, iss_cyc = -1, rv_cyc = -1, ack_cyc = -1;
    int streak = 0;
    int wait_fixed = 0;
    bit rand_on = 0, stray_on = 0;
    bit own_d, exp_we, exp_err;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, rv_data;
    int last_iack_cyc = -1, last_dack_cyc = -1, last_mreq_cyc = -1, last_err_cyc = -1;
    int n_iack = 0, n_dack = 0, n_mreq = 0, ack_cnt = 0;
    logic [15:0] ack_log = '0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_ctl"}, {i_ack, d_ack, mem_req, err, mem_we}, '0);
        check_val({tag, "_be"}, mem_be, '0);
        check_val({tag, "_addr"}, mem_addr, '0);
        check_val({tag, "_wdata"}, mem_wdata, '0);
        check_val({tag, "_irdata"}, i_rdata, '0);
        check_val({tag, "_drdata"}, d_rdata, '0);
    endtask

    task automatic schedule(input int c, input bit is_d);
        int w;
        logic [7:0] idx;
        w = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 3));
        own_d   = is_d;
        iss_cyc = c + 1;
        rv_cyc  = c + 1 + w;
        ack_cyc = c + 2 + w;
        exp_err = 1'b0;
        if (is_d) begin
            exp_we = d_q[0].we; exp_be = d_q[0].be;
            exp_addr = d_q[0].addr; exp_wdata = d_q[0].wdata;
        end else begin
            exp_we = 1'b0; exp_be = BE_ALL; exp_addr = i_q[0]; exp_wdata = '0;
        end
        idx = exp_addr[9:2];
        if (exp_we) begin
            for (int b = 0; b < 4; b++)
                if (exp_be[b]) mem[idx][8*b +: 8] = exp_wdata[8*b +: 8];
            exp_rdata = '0;
            rv_data   = $urandom();
        end else begin
            exp_rdata = mem[idx];
            rv_data   = mem[idx];
        end
`ifdef RISCV_MEM_ARB_TIMEOUT_EN
        if (w > int'(TMO)) begin
            ack_cyc   = c + 2 + int'(TMO);
            rv_cyc    = -1;
            exp_err   = 1'b1;
            exp_rdata = '0;
        end
`endif
        free_at = ack_cyc;
    endtask

    task automatic step();
        bit ia, da, idle_now;
        @(negedge clk);
        cyc++;
        ia = (cyc == ack_cyc) && !own_d;
        da = (cyc == ack_cyc) && own_d;
        check_val("mem_req", mem_req, cyc == iss_cyc);
        if (cyc == iss_cyc) begin
            check_val("mem_addr", mem_addr, exp_addr);
            check_val("mem_we", mem_we, exp_we);
            check_val("mem_be", mem_be, exp_be);
            if (own_d) check_val("mem_wdata", mem_wdata, exp_wdata);
        end
        check_val("i_ack", i_ack, ia);
        check_val("d_ack", d_ack, da);
        check_val("err", err, (cyc == ack_cyc) && exp_err);
        if (ia) check_val("i_rdata", i_rdata, exp_rdata);
        if (da) check_val("d_rdata", d_rdata, exp_rdata);
        if (i_ack) begin last_iack_cyc = cyc; n_iack++; end
        if (d_ack) begin last_dack_cyc = cyc; n_dack++; end
        if (i_ack || d_ack) begin ack_log = {ack_log[14:0], d_ack}; ack_cnt++; end
        if (mem_req) begin last_mreq_cyc = cyc; n_mreq++; end
        if (err) last_err_cyc = cyc;
        if (ia) void'(i_q.pop_front());
        if (da) void'(d_q.pop_front());
        if (rand_on) begin
            if (i_q.size() < 2 && $urandom_range(0, 3) == 0)
                i_q.push_back({22'd0, 8'($urandom_range(0, 255)), 2'b00});
            if (d_q.size() < 2 && $urandom_range(0, 2) == 0)
                d_q.push_back({1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                               {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'($urandom())});
        end
        i_req  = (i_q.size() != 0);
        i_addr = i_req ? i_q[0] : 32'($urandom());
        d_req  = (d_q.size() != 0);
        if (d_req) begin
            d_we = d_q[0].we; d_be = d_q[0].be; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
        end else begin
            d_we = 1'($urandom()); d_be = 4'($urandom()); d_addr = $urandom(); d_wdata = $urandom();
        end
        idle_now = (cyc >= free_at);
        if (idle_now) begin
            if (d_req && !(i_req && streak == int'(MAXS))) begin
                streak = i_req ? ((streak < int'(MAXS)) ? streak + 1 : streak) : 0;
                schedule(cyc, 1'b1);
            end else if (i_req) begin
                streak = 0;
                schedule(cyc, 1'b0);
            end else begin
                streak = 0;
            end
        end
        mem_rvalid = (cyc == rv_cyc) || (idle_now && stray_on && $urandom_range(0, 7) == 0);
        mem_rdata  = (cyc == rv_cyc) ? rv_data : 32'($urandom());
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((i_q.size() != 0 || d_q.size() != 0 || cyc < free_at) && n < max_cyc) begin
            step();
            n++;
        end
        check_val("drain_done", (i_q.size() != 0 || d_q.size() != 0 || cyc < free_at), 0);
    endtask

    initial begin
        int t0, ni0, nd0, nm0, n;
        for (int k = 0; k < 256; k++) mem[k] = $urandom();
        rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
            check_quiet("reset");
        end
        rst = 1'b0;
        free_at = 0;

        // Single zero-wait fetch.
        mem[8'h40] = 32'h0000_0013;
        wait_fixed = 0;
        i_q.push_back(32'h100);
        t0 = cyc + 1;
        drain(20);
        check_val("fetch_mreq_cyc", last_mreq_cyc - t0, 1);
        check_val("fetch_ack_cyc", last_iack_cyc - t0, 2);

        // Simultaneous fetch and store: store wins, fetch issues right after d_ack.
        ni0 = n_iack; nd0 = n_dack;
        i_q.push_back(32'h0);
        d_q.push_back({1'b1, 4'hF, 32'h200, 32'hCAFE_F00D});
        drain(20);
        check_val("sim_i_after_d", last_mreq_cyc - last_dack_cyc, 1);
        check_val("sim_acks", {8'(n_iack - ni0), 8'(n_dack - nd0)}, 16'h0101);
        check_val("sim_mem", mem[8'h80], 32'hCAFE_F00D);

        // Streak limit: both held, expect D D D D I D D I.
        ack_log = '0; ack_cnt = 0;
        repeat (6) d_q.push_back({1'b0, 4'hF, 32'h1F0, 32'h0});
        repeat (2) i_q.push_back(32'h10);
        drain(60);
        check_val("streak_cnt", ack_cnt, 8);
        check_val("streak_order", ack_log[7:0], 8'b1111_0110);

        // Three wait cycles on a load.
        mem[8'hC0] = 32'h1234_5678;
        wait_fixed = 3;
        nm0 = n_mreq;
        d_q.push_back({1'b0, 4'hF, 32'h300, 32'h0});
        t0 = cyc + 1;
        drain(20);
        check_val("wait3_ack_cyc", last_dack_cyc - t0, 5);
        check_val("wait3_mreq_cnt", n_mreq - nm0, 1);

`ifdef RISCV_MEM_ARB_TIMEOUT_EN
        // Memory never answers: watchdog completes the fetch with err.
        wait_fixed = 1000;
        i_q.push_back(32'h40);
        drain(40);
        check_val("tmo_ack_cyc", last_iack_cyc - last_mreq_cyc, 9);
        check_val("tmo_err_cyc", last_err_cyc, last_iack_cyc);
`endif

        // Random traffic with random wait states and stray completions.
        wait_fixed = -1; rand_on = 1; stray_on = 1;
        repeat (3000) step();
        rand_on = 0;
        drain(100);
        check_val("rand_fetches", n_iack > 20, 1);

        // Reset while a store is outstanding; the late completion must be dropped.
        stray_on = 0; wait_fixed = 1000;
        d_q.push_back({1'b1, 4'h3, 32'h80, 32'h1111_2222});
        n = 0;
        while (cyc != iss_cyc && n < 10) begin step(); n++; end
        check_val("rst_reached_wait", cyc == iss_cyc, 1);
        rst = 1'b1;
        d_q.delete();
        d_req = 0; i_req = 0;
        iss_cyc = -1; rv_cyc = -1; ack_cyc = -1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            cyc++;
            check_quiet("rst_mid");
            if (k == 0) rst = 1'b0;
            mem_rvalid = (k == 2);
            mem_rdata  = $urandom();
        end
        mem_rvalid = 0;
        free_at = 0; streak = 0; wait_fixed = 0;

        // Traffic resumes normally after the abandoned access.
        i_q.push_back(32'h100);
        drain(20);
        check_val("post_rst_fetch", i_rdata == 32'h13 || last_iack_cyc > 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
